// File: rtl/demux_pkg.sv
// Shared types and constants for the 1-to-4 stream demultiplexer.
package demux_pkg;

    localparam int unsigned NUM_LANES = 4;

    typedef logic [1:0] lane_sel_t;

    // Replicated to the data width wherever a lane word is cleared.
    localparam logic RESET_DATA_BIT = 1'b0;

endpackage

// File: rtl/demux_lane_buf.sv
// One-entry output lane buffer with valid/ready drain. It can accept a new
// word when it is empty or when its current word is drained this cycle.
module demux_lane_buf
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] load_data,
    input  logic             drain_ready,
    output logic             valid,
    output logic [WIDTH-1:0] data,
    output logic             can_accept
);

    logic             valid_q, valid_d;
    logic [WIDTH-1:0] data_q,  data_d;

    // A load wins over a drain: the new word replaces the drained one.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        if (load) begin
            valid_d = 1'b1;
            data_d  = load_data;
        end else if (drain_ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            valid_q <= 1'b0;
            data_q  <= {WIDTH{RESET_DATA_BIT}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign valid      = valid_q;
    assign data       = data_q;
    assign can_accept = !valid_q || drain_ready;

endmodule

// File: rtl/demux1_4_stream.sv
// Registered 1-to-4 stream demultiplexer: steers each accepted input word
// into the one-entry buffer of the lane named by in_sel.
module demux1_4_stream
    import demux_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [NUM_LANES-1:0] out_valid,
    input  logic [NUM_LANES-1:0] out_ready,
    output logic [WIDTH-1:0]     out_data0,
    output logic [WIDTH-1:0]     out_data1,
    output logic [WIDTH-1:0]     out_data2,
    output logic [WIDTH-1:0]     out_data3,
    output logic                 busy
);

    lane_sel_t            sel;
    logic                 in_fire;
    logic [NUM_LANES-1:0] lane_load;
    logic [NUM_LANES-1:0] lane_can_accept;
    logic [NUM_LANES-1:0] lane_valid;
    logic [WIDTH-1:0]     lane_data [NUM_LANES];

    assign sel      = in_sel;
    // Readiness looks only at the selected lane, so a stalled lane never
    // blocks words headed elsewhere.
    assign in_ready = lane_can_accept[sel];
    assign in_fire  = in_valid && in_ready;

    always_comb begin
        lane_load = '0;
        for (int unsigned k = 0; k < NUM_LANES; k++) begin
            lane_load[k] = in_fire && (sel == lane_sel_t'(k));
        end
    end

    for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
        demux_lane_buf #(
            .WIDTH(WIDTH)
        ) u_buf (
            .CLK        (CLK),
            .RST        (RST),
            .load       (lane_load[g]),
            .load_data  (in_data),
            .drain_ready(out_ready[g]),
            .valid      (lane_valid[g]),
            .data       (lane_data[g]),
            .can_accept (lane_can_accept[g])
        );
    end

    assign out_valid = lane_valid;
    assign out_data0 = lane_data[0];
    assign out_data1 = lane_data[1];
    assign out_data2 = lane_data[2];
    assign out_data3 = lane_data[3];
    assign busy      = |lane_valid;

endmodule
